run_check_ctrl: RTL and testbench

//   Synthesisable self-checking harness controller for the processor. Holds the DUT in

---
 rtl/run_check_ctrl_if.sv | 40 ++++
 rtl/run_check_ctrl.sv | 132 +++++++++++++
 tb/tb_run_check_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/run_check_ctrl_if.sv
// run_check_ctrl_if: signal bundle between host, run-check controller and processor under test
interface run_check_ctrl_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_MEM  = 16,
    parameter int ERR_W    = 8
);
    localparam int IDX_N = NUM_REGS > NUM_MEM ? NUM_REGS : NUM_MEM;
    localparam int IDX_W = IDX_N > 1 ? $clog2(IDX_N) : 1;
    localparam int RA_W  = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
    localparam int MA_W  = NUM_MEM > 1 ? $clog2(NUM_MEM) : 1;
    logic              start;
    logic              exp_we;
    logic              exp_sel;
    logic [IDX_W-1:0]  exp_idx;
    logic              exp_en;
    logic [DATA_W-1:0] exp_data;
    logic              dut_reset;
    logic [RA_W-1:0]   reg_addr;
    logic [DATA_W-1:0] reg_rdata;
    logic [MA_W-1:0]   mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_count;
    logic              first_err_sel;
    logic [IDX_W-1:0]  first_err_idx;
    logic [DATA_W-1:0] first_err_got;
    modport slave (
        input  start, exp_we, exp_sel, exp_idx, exp_en, exp_data, reg_rdata, mem_rdata,
        output dut_reset, reg_addr, mem_addr, busy, done, pass, err_count,
               first_err_sel, first_err_idx, first_err_got
    );
    modport master (
        output start, exp_we, exp_sel, exp_idx, exp_en, exp_data, reg_rdata, mem_rdata,
        input  dut_reset, reg_addr, mem_addr, busy, done, pass, err_count,
               first_err_sel, first_err_idx, first_err_got
    );
endinterface

// File: rtl/run_check_ctrl.sv
// run_check_ctrl: holds the processor in reset, runs it for a fixed budget, then scans and checks its state
module run_check_ctrl #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_MEM  = 16,
    parameter int HOLD_CYC = 2,
    parameter int RUN_CYC  = 50,
    parameter int ERR_W    = 8
) (
    input logic clk,
    input logic reset,
    run_check_ctrl_if.slave bus
);
    localparam int IDX_N = NUM_REGS > NUM_MEM ? NUM_REGS : NUM_MEM;
    localparam int IDX_W = IDX_N > 1 ? $clog2(IDX_N) : 1;
    localparam int RA_W  = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
    localparam int MA_W  = NUM_MEM > 1 ? $clog2(NUM_MEM) : 1;
    localparam int MEM_D = NUM_MEM > 0 ? NUM_MEM : 1;
    localparam int CMAX  = HOLD_CYC > RUN_CYC ? HOLD_CYC : RUN_CYC;
    localparam int CNT_W = CMAX > 1 ? $clog2(CMAX) : 1;
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] HOLD    = 3'd1;
    localparam logic [2:0] RUN     = 3'd2;
    localparam logic [2:0] CHK_REG = 3'd3;
    localparam logic [2:0] CHK_MEM = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    logic [2:0]        state, nxt;
    logic [CNT_W-1:0]  cnt;
    logic [RA_W-1:0]   ra;
    logic [MA_W-1:0]   ma;
    logic [DATA_W-1:0] reg_tab [NUM_REGS];
    logic [DATA_W-1:0] mem_tab [MEM_D];
    logic [NUM_REGS-1:0] reg_en;
    logic [MEM_D-1:0]  mem_en;
    logic              dut_rst_q;
    logic [ERR_W-1:0]  err;
    logic              fe_sel;
    logic [IDX_W-1:0]  fe_idx;
    logic [DATA_W-1:0] fe_got;
    logic busy, chk_reg, chk_mem, reg_last, mem_last, wr_reg, wr_mem, hit, enter_hold;
    assign busy       = state inside {HOLD, RUN, CHK_REG, CHK_MEM};
    assign chk_reg    = state == CHK_REG;
    assign chk_mem    = state == CHK_MEM;
    assign reg_last   = ra == RA_W'(NUM_REGS - 1);
    assign mem_last   = ma == MA_W'(MEM_D - 1);
    assign enter_hold = nxt == HOLD && state != HOLD;
    assign wr_reg     = bus.exp_we && !busy && !bus.exp_sel && 32'(bus.exp_idx) < NUM_REGS;
    assign wr_mem     = bus.exp_we && !busy && bus.exp_sel && 32'(bus.exp_idx) < NUM_MEM;
    assign hit        = chk_reg ? (reg_en[ra] && bus.reg_rdata != reg_tab[ra])
                                : (chk_mem && mem_en[ma] && bus.mem_rdata != mem_tab[ma]);
    assign bus.dut_reset     = dut_rst_q;
    assign bus.reg_addr      = ra;
    assign bus.mem_addr      = ma;
    assign bus.busy          = busy;
    assign bus.done          = state == DONE;
    assign bus.pass          = state == DONE && err == '0;
    assign bus.err_count     = err;
    assign bus.first_err_sel = fe_sel;
    assign bus.first_err_idx = fe_idx;
    assign bus.first_err_got = fe_got;
    // Sequence decode: start only honoured when idle or done, phases end when their counter or index runs out
    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE: nxt = bus.start ? HOLD : state;
            HOLD:       nxt = cnt == '0 ? RUN : HOLD;
            RUN:        nxt = cnt == '0 ? CHK_REG : RUN;
            CHK_REG:    nxt = reg_last ? (NUM_MEM > 0 ? CHK_MEM : DONE) : CHK_REG;
            CHK_MEM:    nxt = mem_last ? DONE : CHK_MEM;
            default:    nxt = IDLE;
        endcase
    end
    // State, phase counter, scan indices and error capture; dut_reset is registered so it cannot glitch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            ra        <= '0;
            ma        <= '0;
            dut_rst_q <= 1'b1;
            err       <= '0;
            fe_sel    <= 1'b0;
            fe_idx    <= '0;
            fe_got    <= '0;
        end else begin
            state     <= nxt;
            dut_rst_q <= !(nxt inside {RUN, CHK_REG, CHK_MEM});
            if (enter_hold)
                cnt <= CNT_W'(HOLD_CYC - 1);
            else if (nxt == RUN && state != RUN)
                cnt <= CNT_W'(RUN_CYC - 1);
            else if (cnt != '0)
                cnt <= cnt - 1'b1;
            ra <= (chk_reg && !reg_last) ? ra + 1'b1 : '0;
            ma <= (chk_mem && !mem_last) ? ma + 1'b1 : '0;
            if (enter_hold) begin
                err    <= '0;
                fe_sel <= 1'b0;
                fe_idx <= '0;
                fe_got <= '0;
            end else if (hit) begin
                if (err == '0) begin
                    fe_sel <= chk_mem;
                    fe_idx <= chk_mem ? IDX_W'(ma) : IDX_W'(ra);
                    fe_got <= chk_mem ? bus.mem_rdata : bus.reg_rdata;
                end
                if (err != ERR_MAX)
                    err <= err + 1'b1;
            end
        end
    end
    // Entry enables are cleared by reset so a fresh table checks nothing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_en <= '0;
            mem_en <= '0;
        end else begin
            if (wr_reg)
                reg_en[bus.exp_idx[RA_W-1:0]] <= bus.exp_en;
            if (wr_mem)
                mem_en[bus.exp_idx[MA_W-1:0]] <= bus.exp_en;
        end
    end
    // Expected values need no reset; their enables gate whether they matter
    always_ff @(posedge clk) begin
        if (wr_reg)
            reg_tab[bus.exp_idx[RA_W-1:0]] <= bus.exp_data;
        if (wr_mem)
            mem_tab[bus.exp_idx[MA_W-1:0]] <= bus.exp_data;
    end
endmodule

// File: tb/tb_run_check_ctrl.sv
// tb_run_check_ctrl: scoreboard bench for the run-check controller with a modelled register file and memory
module tb_run_check_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int nvec = 0;
    int nerr = 0;
    logic [31:0] rf [32];
    logic [31:0] dm [16];
    typedef struct {
        logic        pass;
        logic [3:0]  err;
        logic        sel;
        logic [4:0]  idx;
        logic [31:0] got;
        int          lat;
        int          low;
    } exp_t;
    exp_t sb[$];

    run_check_ctrl_if #(.DATA_W(32), .NUM_REGS(32), .NUM_MEM(16), .ERR_W(4)) bus ();

    run_check_ctrl #(.DATA_W(32), .NUM_REGS(32), .NUM_MEM(16), .HOLD_CYC(2), .RUN_CYC(50), .ERR_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.reg_rdata = rf[bus.reg_addr];
    assign bus.mem_rdata = dm[bus.mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input logic sel, input int idx, input logic en, input logic [31:0] data, input logic go);
        @(negedge clk);
        bus.exp_we = 1'b1;
        bus.exp_sel = sel;
        bus.exp_idx = 5'(idx);
        bus.exp_en = en;
        bus.exp_data = data;
        bus.start = go;
        @(negedge clk);
        bus.exp_we = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic go();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int n = 0;
        while (!bus.done && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(bus.done), 32'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: measures latency and dut_reset-low time per run, pops the scoreboard on each done rise
    initial begin
        bit armed;
        int cyc, low;
        logic done_q;
        exp_t e;
        armed = 0; cyc = 0; low = 0; done_q = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                armed = 0;
                done_q = 1'b0;
            end else begin
                if (armed) begin
                    cyc++;
                    if (!bus.dut_reset) low++;
                end
                if (bus.done && !done_q) begin
                    if (sb.size() == 0) begin
                        chk("spurious_done", 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb.pop_front();
                        chk("pass", 32'(bus.pass), 32'(e.pass));
                        chk("err_count", 32'(bus.err_count), 32'(e.err));
                        chk("first_err_sel", 32'(bus.first_err_sel), 32'(e.sel));
                        chk("first_err_idx", 32'(bus.first_err_idx), 32'(e.idx));
                        chk("first_err_got", bus.first_err_got, e.got);
                        chk("latency", armed ? cyc : -1, e.lat);
                        chk("dut_reset_low", low, e.low);
                    end
                    armed = 0;
                end
                done_q = bus.done;
                if (bus.start && !bus.busy) begin
                    armed = 1;
                    cyc = 0;
                    low = 0;
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [31:0] xv [13] = '{0, 1, 2, 3, 1, 0, 3, 3, 1, 1, 2, 0, 3};
        int n;
        for (int i = 0; i < 32; i++) rf[i] = i < 13 ? xv[i] : 32'd0;
        rf[13] = 32'h38;
        for (int i = 0; i < 16; i++) dm[i] = 32'd0;
        dm[0] = 32'd3;
        bus.start = 1'b0; bus.exp_we = 1'b0; bus.exp_sel = 1'b0;
        bus.exp_idx = '0; bus.exp_en = 1'b0; bus.exp_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_dut_reset", 32'(bus.dut_reset), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_pass", 32'(bus.pass), 32'd0);
        chk("rst_err", 32'(bus.err_count), 32'd0);
        chk("rst_fe_idx", 32'(bus.first_err_idx), 32'd0);
        chk("rst_fe_got", bus.first_err_got, 32'd0);
        chk("rst_reg_addr", 32'(bus.reg_addr), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        reset = 1'b0;
        // 1: program results match the table
        for (int i = 1; i <= 12; i++) load(1'b0, i, 1'b1, xv[i], 1'b0);
        load(1'b0, 13, 1'b1, 32'h38, 1'b0);
        load(1'b1, 0, 1'b1, 32'd3, 1'b0);
        sb.push_back('{1'b1, 4'd0, 1'b0, 5'd0, 32'd0, 101, 98});
        go();
        wait_done(300);
        // 2: x13 expectation wrong, written in the same cycle as start
        sb.push_back('{1'b0, 4'd1, 1'b0, 5'd13, 32'h38, 101, 98});
        load(1'b0, 13, 1'b1, 32'h3C, 1'b1);
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        wait_done(300);
        // 3: every entry wrong, counter saturates
        for (int i = 0; i < 32; i++) load(1'b0, i, 1'b1, ~rf[i], 1'b0);
        for (int i = 0; i < 16; i++) load(1'b1, i, 1'b1, ~dm[i], 1'b0);
        sb.push_back('{1'b0, 4'd15, 1'b0, 5'd0, 32'd0, 101, 98});
        go();
        wait_done(300);
        // 4: cleared table; out-of-range and busy writes are dropped
        pulse_reset();
        load(1'b1, 20, 1'b1, 32'hDEAD, 1'b0);
        sb.push_back('{1'b1, 4'd0, 1'b0, 5'd0, 32'd0, 101, 98});
        go();
        repeat (10) @(negedge clk);
        load(1'b0, 1, 1'b1, 32'h999, 1'b0);
        wait_done(300);
        // 5: start during RUN is ignored; restart from DONE clears the error count
        load(1'b0, 13, 1'b1, 32'h3C, 1'b0);
        sb.push_back('{1'b0, 4'd1, 1'b0, 5'd13, 32'h38, 101, 98});
        go();
        repeat (20) @(negedge clk);
        go();
        wait_done(300);
        load(1'b0, 13, 1'b1, 32'h38, 1'b0);
        sb.push_back('{1'b1, 4'd0, 1'b0, 5'd0, 32'd0, 101, 98});
        go();
        chk("restart_err_clr", 32'(bus.err_count), 32'd0);
        wait_done(300);
        // 6: reset in the middle of the register scan
        load(1'b0, 13, 1'b1, 32'h3C, 1'b0);
        go();
        n = 0;
        while (bus.reg_addr != 5'd20 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("scan_reached", 32'(bus.reg_addr), 32'd20);
        chk("mid_err", 32'(bus.err_count), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_dut_reset", 32'(bus.dut_reset), 32'd1);
        chk("abort_err", 32'(bus.err_count), 32'd0);
        chk("abort_reg_addr", 32'(bus.reg_addr), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb.push_back('{1'b1, 4'd0, 1'b0, 5'd0, 32'd0, 101, 98});
        go();
        wait_done(300);
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
